tetris_game_core: RTL
=====================

// Module: tetris_game_core
// PURPOSE
//  Falling-block game engine; the "tetris" stage of BitsPlease between ButtonDecoder and the displays.
//  Consumes shaped game button pulses and produces the 8x8 playfield image for LEDMatrixControllerTop
//  and the running score for DisplayScoreMux / ScoreBoardMain.
//  Pieces are 2-cell dominoes (horizontal or vertical); full rows clear and add to score.
// PARAMETERS
//  GRAVITY_TICKS  25_000_000  clk cycles per gravity step (>=2; bench uses 4)
//  ROW_POINTS     1           score added per cleared row
//  SEED           8'hA5       LFSR reset value (must be nonzero)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous, active-high reset
//  start       in   1   1-cycle pulse: begin new game (honoured in IDLE and GAME_OVER only)
//  buttons     in   3   1-cycle pulses: [0] left, [1] right, [2] rotate
//  matrix_out  out  64  playfield image; bit 8*r+c = row r (0=top), col c (0=left)
//  score       out  32  current game score, unsigned, saturating
//  playing     out  1   1 while in SPAWN/FALL/LOCK/CLEAR
//  game_over   out  1   1 while in GAME_OVER
// BEHAVIOUR
//  Reset: state=IDLE, board=0, piece invalid, score=0, gravity cnt=0, LFSR=SEED; all outputs 0.
//  Regs: board[63:0], piece row pr[2:0], col pc[2:0], orient po (0=H,1=V), cnt, lfsr[7:0].
//  Piece cells: H -> (pr,pc),(pr,pc+1); V -> (pr,pc),(pr+1,pc).
//  matrix_out = board | piece cells (piece only while FALL); combinational from regs.
//  LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, steps every cycle in every state.
//  States:
//   IDLE     : start -> board=0, score=0, SPAWN.
//   SPAWN    : 1 cycle. pr=0, pc=3, po=lfsr[0], cnt=0. Cells overlap board -> GAME_OVER, else FALL.
//   FALL     : if cnt==GRAVITY_TICKS-1: cnt=0; down-move legal -> pr+1, else -> LOCK.
//              else cnt+1 and at most one button applied, priority left > right > rotate:
//              left: pc-1 if pc>0 and cells free; right: pc+1 if rightmost cell col<7 and free;
//              rotate: toggle po if new cells in-bounds (V needs pr<7, H needs pc<7) and free.
//              Illegal moves ignored silently. Buttons arriving on a gravity-tick cycle are dropped.
//   LOCK     : 1 cycle. board |= piece cells -> CLEAR.
//   CLEAR    : each cycle find lowest full row (0xFF); if found: delete it, shift rows above down
//              one, row 0 = 0, score += ROW_POINTS (saturate at 32'hFFFF_FFFF), stay. None -> SPAWN.
//              One cycle per cleared row; final no-full-row cycle precedes SPAWN.
//   GAME_OVER: board and score held; piece not shown; start -> new game as from IDLE.
//  start outside IDLE/GAME_OVER ignored. Buttons outside FALL ignored.
//  Down-move legal: V needs pr+1<=6, H needs pr<=6, and target cells free.
//  Async rst at any time returns to reset values immediately; no partial state survives.
//  score is not cleared on GAME_OVER; only on rst or a new start.
// TESTING (GRAVITY_TICKS=4; bench carries an LFSR model to predict po)
//  1 rst asserted mid-FALL -> matrix_out=0, score=0, playing=0, game_over=0 same cycle.
//  2 start, no buttons -> SPAWN next cycle, piece drops one row every 4 cycles, locks in row 7
//    (H: bits 59,60 set; V: bits 51,59 set); playing stays 1.
//  3 start, then 5 left pulses (non-tick cycles) -> pc clamps at 0; 6th left no change.
//  4 left+right+rotate same cycle -> only left applied; pulse on tick cycle -> ignored.
//  5 preload via play so row 7 needs one H piece -> after LOCK, row 7 cleared, rows shift,
//    score=1; two full rows -> score=2, two CLEAR cycles.
//  6 stack col 3-4 to row 0 -> next SPAWN overlaps -> game_over=1, playing=0, score held;
//    start -> board=0, score=0, playing=1.

Source files
------------

// File: rtl/tetris_game_core_if.sv
// Bundles the game controls and display outputs of tetris_game_core.
// Handshake: start and buttons are single-cycle pulses with valid-only
// semantics; the core has no ready/back-pressure and samples them on every clk
// edge. A pulse the current state cannot use is dropped. All outputs are
// registered-state images that the consumer may read at any time.
interface tetris_game_core_if;
   logic        start;       // begin a new game (IDLE / GAME_OVER only)
   logic [2:0]  buttons;     // [0] left, [1] right, [2] rotate
   logic [63:0] matrix_out;  // bit 8*r+c = row r (0=top), col c (0=left)
   logic [31:0] score;       // saturating row-clear score
   logic        playing;     // SPAWN/FALL/LOCK/CLEAR
   logic        game_over;   // GAME_OVER
   logic [2:0]  fsm_state;   // raw FSM state for debug visibility

   modport master (
      output start, buttons,
      input  matrix_out, score, playing, game_over, fsm_state
   );

   modport slave (
      input  start, buttons,
      output matrix_out, score, playing, game_over, fsm_state
   );
endinterface

// File: rtl/tetris_game_core.sv
// Falling-domino game engine on an 8x8 board. A 2-cell piece (horizontal or
// vertical, picked by an LFSR bit) spawns at row 0 col 3, moves on button
// pulses, falls once per GRAVITY_TICKS cycles, locks into the board, and full
// rows are removed one per cycle while the score is bumped.
module tetris_game_core #(
   parameter int unsigned GRAVITY_TICKS = 25_000_000,
   parameter int unsigned ROW_POINTS    = 1,
   parameter logic [7:0]  SEED          = 8'hA5
) (
   input logic          clk,
   input logic          rst,
   tetris_game_core_if.slave bus
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SPAWN = 3'd1;
   localparam logic [2:0] ST_FALL  = 3'd2;
   localparam logic [2:0] ST_LOCK  = 3'd3;
   localparam logic [2:0] ST_CLEAR = 3'd4;
   localparam logic [2:0] ST_OVER  = 3'd5;

   // GRAVITY_TICKS >= 2, so the counter is at least one bit wide.
   localparam int              CW       = $clog2(GRAVITY_TICKS);
   localparam logic [CW-1:0]   CNT_LAST = CW'(GRAVITY_TICKS - 1);
   localparam logic [32:0]     PTS      = 33'(ROW_POINTS);

   logic [2:0]    state;
   logic [63:0]   board;
   logic [2:0]    pr;
   logic [2:0]    pc;
   logic          po;        // 0 = horizontal, 1 = vertical
   logic [CW-1:0] cnt;
   logic [7:0]    lfsr;
   logic [31:0]   score;

   // Cells of a piece anchored at (r,c). Callers only use the result where the
   // second cell is in bounds, so the wrap of an out-of-range shift is harmless.
   function automatic logic [63:0] piece_mask(input logic [2:0] r,
                                              input logic [2:0] c,
                                              input logic       o);
      logic [63:0] m;
      m = 64'd1 << {r, c};
      if (o) m = m | (m << 8);
      else   m = m | (m << 1);
      return m;
   endfunction

   logic [63:0] cur_mask;
   logic [63:0] spawn_mask;
   logic [2:0]  right_col;
   logic        left_ok;
   logic        right_ok;
   logic        rot_ok;
   logic        down_ok;
   logic        spawn_blocked;

   // Legality of every candidate move, evaluated against the locked board.
   always_comb begin
      cur_mask      = piece_mask(pr, pc, po);
      spawn_mask    = piece_mask(3'd0, 3'd3, lfsr[0]);
      spawn_blocked = (spawn_mask & board) != 64'd0;
      right_col     = po ? pc : pc + 3'd1;
      left_ok  = (pc != 3'd0) &&
                 ((piece_mask(pr, pc - 3'd1, po) & board) == 64'd0);
      right_ok = (right_col != 3'd7) &&
                 ((piece_mask(pr, pc + 3'd1, po) & board) == 64'd0);
      rot_ok   = (po ? (pc != 3'd7) : (pr != 3'd7)) &&
                 ((piece_mask(pr, pc, ~po) & board) == 64'd0);
      down_ok  = (po ? (pr <= 3'd5) : (pr <= 3'd6)) &&
                 ((piece_mask(pr + 3'd1, pc, po) & board) == 64'd0);
   end

   logic       full_found;
   logic [2:0] full_row;

   // Lowest (highest-index) completely filled row on the board.
   always_comb begin
      full_found = 1'b0;
      full_row   = 3'd0;
      for (int r = 0; r < 8; r++) begin
         if (board[8*r +: 8] == 8'hFF) begin
            full_found = 1'b1;
            full_row   = 3'(r);
         end
      end
   end

   logic [63:0] shifted;

   // Board with full_row removed: rows above drop one, row 0 becomes empty.
   always_comb begin
      shifted = '0;
      for (int r = 1; r < 8; r++) begin
         if (r > int'(full_row)) shifted[8*r +: 8] = board[8*r +: 8];
         else                    shifted[8*r +: 8] = board[8*(r-1) +: 8];
      end
   end

   logic [32:0] score_sum;
   logic [31:0] score_next;

   // Saturating score increment for one cleared row.
   always_comb begin
      score_sum  = {1'b0, score} + PTS;
      score_next = score_sum[32] ? 32'hFFFF_FFFF : score_sum[31:0];
   end

   // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1, steps in every state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= SEED;
      else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   // Game FSM: spawn, move/fall, lock, row clearing, game over.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         board <= '0;
         pr    <= '0;
         pc    <= '0;
         po    <= 1'b0;
         cnt   <= '0;
         score <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_OVER: begin
               if (bus.start) begin
                  board <= '0;
                  score <= '0;
                  state <= ST_SPAWN;
               end
            end
            ST_SPAWN: begin
               pr    <= 3'd0;
               pc    <= 3'd3;
               po    <= lfsr[0];
               cnt   <= '0;
               state <= spawn_blocked ? ST_OVER : ST_FALL;
            end
            ST_FALL: begin
               if (cnt == CNT_LAST) begin
                  // Gravity step owns this cycle; any button pulse is dropped.
                  cnt <= '0;
                  if (down_ok) pr    <= pr + 3'd1;
                  else         state <= ST_LOCK;
               end else begin
                  cnt <= cnt + CW'(1);
                  if (bus.buttons[0]) begin
                     if (left_ok) pc <= pc - 3'd1;
                  end else if (bus.buttons[1]) begin
                     if (right_ok) pc <= pc + 3'd1;
                  end else if (bus.buttons[2]) begin
                     if (rot_ok) po <= ~po;
                  end
               end
            end
            ST_LOCK: begin
               board <= board | cur_mask;
               state <= ST_CLEAR;
            end
            ST_CLEAR: begin
               if (full_found) begin
                  board <= shifted;
                  score <= score_next;
               end else begin
                  state <= ST_SPAWN;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.matrix_out = board | ((state == ST_FALL) ? cur_mask : 64'd0);
   assign bus.score      = score;
   assign bus.playing    = (state == ST_SPAWN) || (state == ST_FALL) ||
                           (state == ST_LOCK)  || (state == ST_CLEAR);
   assign bus.game_over  = (state == ST_OVER);
   assign bus.fsm_state  = state;

endmodule
